rxana_param: RTL and testbench

- Parametrised successor of the bus receive parser.
- Consumes the byte stream from the bus receiver and parses addressed frames.
- Checks length and CRC-16/MODBUS, and aborts stalled frames on an inter-byte timeout.
- Dispatches read commands to the bus reply generator and write commands to the sensor command block; reports frame errors.

---
 rtl/rxana_pkg.sv | 13 +
 rtl/crc16_byte.sv | 14 +
 rtl/rxana_param.sv | 142 ++++++++++++++
 tb/tb_rxana_param.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rxana_pkg.sv
// rxana_pkg: shared FSM states, error codes and CRC constants for the bus receive parser.
package rxana_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_ID_L, S_LEN_H, S_LEN_L, S_SID, S_RW, S_DATA, S_CRC_L, S_CRC_H, S_SKIP
   } state_t;
   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_CRC  = 2'd1;
   localparam logic [1:0] ERR_LEN  = 2'd2;
   localparam logic [1:0] ERR_TMO  = 2'd3;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam logic [15:0] CRC_POLY = 16'hA001;
   localparam logic [1:0] RW_READ = 2'b11;
endpackage

// File: rtl/crc16_byte.sv
// crc16_byte: combinational CRC-16/MODBUS update by one byte, LSB first.
module crc16_byte
   import rxana_pkg::*;
(
   input  logic [15:0] i_crc,
   input  logic [7:0]  i_byte,
   output logic [15:0] o_crc
);
   always_comb begin
      o_crc = i_crc ^ {8'h00, i_byte};
      for (int i = 0; i < 8; i++)
         o_crc = o_crc[0] ? ((o_crc >> 1) ^ CRC_POLY) : (o_crc >> 1);
   end
endmodule

// File: rtl/rxana_param.sv
// rxana_param: parses addressed bus frames, checks length/CRC/timeout and dispatches read/write commands.
module rxana_param
   import rxana_pkg::*;
#(
   parameter logic [15:0] NODE_ID     = 16'h0001,
   parameter int          DATA_BYTES  = 4,
   parameter int          TIMEOUT_CYC = 100000
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst,
   input  logic                      rx_flag,
   input  logic [7:0]                rx_data,
   output logic [7:0]                ret_cmd,
   output logic                      ret_cmd_flg,
   output logic [8+8*DATA_BYTES-1:0] sen_cmd,
   output logic                      sen_cmd_flag,
   output logic                      frm_err,
   output logic [1:0]                err_code,
   output logic                      busy
);
   localparam int CW = $clog2(DATA_BYTES + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   state_t                  r_state;
   logic [15:0]             r_id, r_len, r_skip, r_crc;
   logic [7:0]              r_sid, r_crc_l;
   logic                    r_read;
   logic [CW-1:0]           r_cnt;
   logic [8*DATA_BYTES-1:0] r_data;
   logic [TW-1:0]           r_tmo;
   logic [15:0]             w_seed, w_crc_next, w_len;
   logic                    w_busy, w_tmo, w_crc_upd;
   // IDLE always seeds from CRC_INIT so the reset-cleared register never leaks into a frame
   assign w_seed    = (r_state == S_IDLE) ? CRC_INIT : r_crc;
   assign w_len     = {r_len[7:0], rx_data};
   assign w_busy    = r_state != S_IDLE;
   assign busy      = w_busy;
   assign w_tmo     = w_busy && !rx_flag && r_tmo == TW'(TIMEOUT_CYC - 1);
   assign w_crc_upd = r_state != S_CRC_L && r_state != S_CRC_H && r_state != S_SKIP;
   crc16_byte u_crc (.i_crc(w_seed), .i_byte(rx_data), .o_crc(w_crc_next));
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state      <= S_IDLE;
         r_id         <= '0;
         r_len        <= '0;
         r_skip       <= '0;
         r_crc        <= '0;
         r_sid        <= '0;
         r_crc_l      <= '0;
         r_read       <= 1'b0;
         r_cnt        <= '0;
         r_data       <= '0;
         r_tmo        <= '0;
         ret_cmd      <= '0;
         ret_cmd_flg  <= 1'b0;
         sen_cmd      <= '0;
         sen_cmd_flag <= 1'b0;
         frm_err      <= 1'b0;
         err_code     <= ERR_NONE;
      end else begin
         ret_cmd_flg  <= 1'b0;
         sen_cmd_flag <= 1'b0;
         frm_err      <= 1'b0;
         r_tmo        <= (rx_flag || !w_busy) ? '0 : r_tmo + TW'(1);
         if (w_tmo) begin
            r_state <= S_IDLE;
            r_crc   <= CRC_INIT;
            if (r_state != S_SKIP) begin
               frm_err  <= 1'b1;
               err_code <= ERR_TMO;
            end
         end else if (rx_flag) begin
            if (w_crc_upd) r_crc <= w_crc_next;
            case (r_state)
               S_IDLE: begin
                  r_id    <= {r_id[7:0], rx_data};
                  r_state <= S_ID_L;
               end
               S_ID_L: begin
                  r_id    <= {r_id[7:0], rx_data};
                  r_state <= S_LEN_H;
               end
               S_LEN_H: begin
                  r_len   <= {r_len[7:0], rx_data};
                  r_state <= S_LEN_L;
               end
               S_LEN_L: begin
                  r_len  <= w_len;
                  r_skip <= w_len;
                  if (r_id == NODE_ID) r_state <= S_SID;
                  else if (w_len == 16'd0) begin
                     r_state <= S_IDLE;
                     r_crc   <= CRC_INIT;
                  end else r_state <= S_SKIP;
               end
               S_SID: begin
                  r_sid   <= rx_data;
                  r_state <= S_RW;
               end
               S_RW: begin
                  r_read  <= rx_data[1:0] == RW_READ;
                  r_cnt   <= '0;
                  r_state <= (rx_data[1:0] == RW_READ) ? S_CRC_L : S_DATA;
               end
               S_DATA: begin
                  r_data[8*r_cnt +: 8] <= rx_data;
                  r_cnt                <= r_cnt + CW'(1);
                  if (r_cnt == CW'(DATA_BYTES - 1)) r_state <= S_CRC_L;
               end
               S_CRC_L: begin
                  r_crc_l <= rx_data;
                  r_state <= S_CRC_H;
               end
               S_CRC_H: begin
                  r_state <= S_IDLE;
                  r_crc   <= CRC_INIT;
                  if (r_len != (r_read ? 16'd4 : 16'(4 + DATA_BYTES))) begin
                     frm_err  <= 1'b1;
                     err_code <= ERR_LEN;
                  end else if ({rx_data, r_crc_l} != r_crc) begin
                     frm_err  <= 1'b1;
                     err_code <= ERR_CRC;
                  end else if (r_read) begin
                     ret_cmd     <= r_sid;
                     ret_cmd_flg <= 1'b1;
                  end else begin
                     sen_cmd      <= {r_sid, r_data};
                     sen_cmd_flag <= 1'b1;
                  end
               end
               S_SKIP: begin
                  r_skip <= r_skip - 16'd1;
                  if (r_skip == 16'd1) begin
                     r_state <= S_IDLE;
                     r_crc   <= CRC_INIT;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_rxana_param.sv
// tb_rxana_param: randomized frame stream checked every cycle against a frame-level model, plus directed cases.
module tb_rxana_param;
   localparam logic [15:0] NODE = 16'h0001;
   localparam int DB = 4;
   localparam int T  = 20;
   typedef logic [7:0] bq_t[$];
   logic sys_clk = 1'b0, sys_rst = 1'b0, rx_flag = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic [7:0] ret_cmd;
   logic ret_cmd_flg, sen_cmd_flag, frm_err, busy;
   logic [8+8*DB-1:0] sen_cmd;
   logic [1:0] err_code;
   rxana_param #(.NODE_ID(NODE), .DATA_BYTES(DB), .TIMEOUT_CYC(T)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_flag(rx_flag), .rx_data(rx_data),
      .ret_cmd(ret_cmd), .ret_cmd_flg(ret_cmd_flg), .sen_cmd(sen_cmd),
      .sen_cmd_flag(sen_cmd_flag), .frm_err(frm_err), .err_code(err_code), .busy(busy)
   );
   always #5 sys_clk = ~sys_clk;
   int checks = 0, errors = 0;
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [15:0] crc16(bq_t q, int n);
      logic [15:0] c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {8'h00, q[i]};
         for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction
   // frame-level model: buffer the bytes of the current frame and judge it once its full length is known
   bq_t fb;
   int idle = 0, n, tot;
   logic [15:0] m_id, m_len, m_rx_crc;
   logic [7:0] m_rw;
   logic [7:0] m_ret = '0;
   logic [8+8*DB-1:0] m_sen = '0;
   logic m_ret_f = 0, m_sen_f = 0, m_err = 0;
   logic [1:0] m_code = '0;
   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         fb.delete(); idle = 0;
         m_ret = '0; m_sen = '0; m_ret_f = 0; m_sen_f = 0; m_err = 0; m_code = '0;
      end else begin
         m_ret_f = 0; m_sen_f = 0; m_err = 0;
         if (rx_flag) begin
            idle = 0;
            fb.push_back(rx_data);
            n = fb.size();
            if (n >= 4) begin
               m_id = {fb[0], fb[1]};
               m_len = {fb[2], fb[3]};
               if (m_id != NODE) begin
                  if (n == 4 + int'(m_len)) fb.delete();
               end else if (n >= 6) begin
                  m_rw = fb[5];
                  tot = (m_rw[1:0] == 2'b11) ? 8 : 8 + DB;
                  if (n == tot) begin
                     m_rx_crc = {fb[tot-1], fb[tot-2]};
                     if (int'(m_len) != tot - 4) begin m_err = 1; m_code = 2; end
                     else if (crc16(fb, tot - 2) != m_rx_crc) begin m_err = 1; m_code = 1; end
                     else if (tot == 8) begin m_ret_f = 1; m_ret = fb[4]; end
                     else begin
                        m_sen_f = 1;
                        m_sen[8*DB +: 8] = fb[4];
                        for (int i = 0; i < DB; i++) m_sen[8*i +: 8] = fb[6+i];
                     end
                     fb.delete();
                  end
               end
            end
         end else if (fb.size() != 0) begin
            idle++;
            if (idle == T) begin
               if (!(fb.size() >= 4 && {fb[0], fb[1]} != NODE)) begin m_err = 1; m_code = 3; end
               fb.delete();
               idle = 0;
            end
         end
      end
   end
   always @(negedge sys_clk) begin
      chk("ret_cmd_flg", ret_cmd_flg, m_ret_f);
      chk("ret_cmd", ret_cmd, m_ret);
      chk("sen_cmd_flag", sen_cmd_flag, m_sen_f);
      chk("sen_cmd", sen_cmd, m_sen);
      chk("frm_err", frm_err, m_err);
      chk("err_code", err_code, m_code);
      chk("busy", busy, fb.size() != 0);
   end
   function automatic bq_t mk(logic [15:0] len, logic [7:0] sid, logic [7:0] rw, bq_t pay, bit bad);
      bq_t q;
      logic [15:0] c;
      q = '{NODE[15:8], NODE[7:0], len[15:8], len[7:0], sid, rw};
      foreach (pay[i]) q.push_back(pay[i]);
      c = crc16(q, q.size());
      q.push_back(c[7:0]);
      q.push_back(bad ? (c[15:8] ^ 8'h01) : c[15:8]);
      return q;
   endfunction
   task automatic send_byte(logic [7:0] b, int gap);
      repeat (gap) @(negedge sys_clk);
      rx_flag = 1'b1;
      rx_data = b;
      @(negedge sys_clk);
      rx_flag = 1'b0;
   endtask
   task automatic send(bq_t q);
      foreach (q[i]) send_byte(q[i], 0);
   endtask
   bq_t pay4 = '{8'h11, 8'h22, 8'h33, 8'h44};
   bq_t none = '{};
   bq_t pin  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
   bq_t f, p;
   initial begin
      bit seen;
      logic [1:0] code;
      #1 sys_rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      chk("rst_busy", busy, 0);
      chk("rst_ret", ret_cmd, 0);
      chk("rst_sen", sen_cmd, 0);
      sys_rst = 1'b0;
      chk("crc_pin", crc16(pin, 9), 16'h4B37);
      send(mk(16'd4, 8'h05, 8'h03, none, 0));
      chk("rd_flag", ret_cmd_flg, 1);
      chk("rd_cmd", ret_cmd, 8'h05);
      chk("rd_noswr", sen_cmd_flag, 0);
      send(mk(16'd8, 8'h07, 8'h00, pay4, 0));
      chk("wr_flag", sen_cmd_flag, 1);
      chk("wr_cmd", sen_cmd, 40'h07_44332211);
      send('{8'h00, 8'h02, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC});
      chk("foreign_idle", busy, 0);
      chk("foreign_noerr", frm_err, 0);
      send(mk(16'd4, 8'h05, 8'h03, none, 0));
      chk("after_foreign", ret_cmd_flg, 1);
      send(mk(16'd4, 8'h05, 8'h03, none, 1));
      chk("crc_err", frm_err, 1);
      chk("crc_code", err_code, 2'd1);
      chk("crc_noflag", ret_cmd_flg, 0);
      send(mk(16'd5, 8'h05, 8'h03, none, 0));
      chk("len_err", frm_err, 1);
      chk("len_code", err_code, 2'd2);
      f = mk(16'd8, 8'h07, 8'h00, pay4, 0);
      for (int i = 0; i < 8; i++) send_byte(f[i], 0);
      seen = 0; code = 0;
      for (int i = 0; i < T + 4; i++) begin
         @(negedge sys_clk);
         if (frm_err) begin seen = 1; code = err_code; end
      end
      chk("tmo_seen", seen, 1);
      chk("tmo_code", code, 2'd3);
      chk("tmo_busy", busy, 0);
      send(mk(16'd4, 8'h09, 8'h03, none, 0));
      chk("tmo_next", ret_cmd, 8'h09);
      for (int i = 0; i < 7; i++) send_byte(f[i], 0);
      #2 sys_rst = 1'b1;
      @(negedge sys_clk);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ret", ret_cmd, 0);
      chk("mid_rst_sen", sen_cmd, 0);
      chk("mid_rst_err", err_code, 0);
      sys_rst = 1'b0;
      send(mk(16'd8, 8'h0A, 8'h01, pay4, 0));
      chk("post_rst_wr", sen_cmd, 40'h0A_44332211);
      for (int k = 0; k < 150; k++) begin
         int kind, stall_at, g;
         kind = $urandom_range(0, 5);
         p.delete();
         for (int i = 0; i < DB; i++) p.push_back(8'($urandom));
         case (kind)
            0: f = mk(16'd4, 8'($urandom), 8'($urandom) | 8'h03, none, 0);
            1: f = mk(16'(4 + DB), 8'($urandom), 8'($urandom) & 8'hFE, p, 0);
            2: f = mk(16'd4, 8'($urandom), 8'h03, none, 1);
            3: f = mk(16'(4 + DB), 8'($urandom), 8'h00, p, 1);
            4: f = mk(16'($urandom_range(0, 9)), 8'($urandom), 8'($urandom), ($urandom_range(0, 1) != 0) ? p : none, 0);
            default: begin
               f = '{8'h00, 8'($urandom_range(2, 255)), 8'h00, 8'($urandom_range(0, 6))};
               for (int i = 0; i < int'(f[3]); i++) f.push_back(8'($urandom));
            end
         endcase
         stall_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, f.size() - 1) : -1;
         for (int i = 0; i < f.size(); i++) begin
            g = $urandom_range(0, 2);
            if (i == stall_at) begin
               g = ($urandom_range(0, 1) != 0) ? T - 1 : T + $urandom_range(0, 3);
               if (g >= T) begin
                  repeat (g) @(negedge sys_clk);
                  break;
               end
            end
            send_byte(f[i], g);
         end
      end
      repeat (T + 5) @(negedge sys_clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
